router_fifo: RTL
================

// Module: router_fifo
// PURPOSE
//  Per-destination output FIFO of the 1x3 router; three instances sit directly downstream of router_sync.
//  Stores bytes of one or more packets, each tagged as header or not, and drives empty/full back to router_sync.
//  Tracks each packet's length from its header and gates data_out between packets.
//  Flushes on soft_reset, which router_sync raises on read timeout.
// PARAMETERS
//  WIDTH  8   payload byte width; stored word is WIDTH+1 bits (MSB = header flag)
//  DEPTH  16  number of entries; power of two
//  AW     4   log2(DEPTH); pointers are AW+1 bits (extra wrap bit)
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous reset, active-low
//  soft_reset  in   1      synchronous flush, active-high, from router_sync
//  write_enb   in   1      write strobe; one bit of router_sync write_enb[2:0]
//  read_enb    in   1      read strobe from destination port
//  lfd_state   in   1      current write byte is a packet header
//  data_in     in   WIDTH  byte to store
//  data_out    out  WIDTH  byte read; registered
//  full        out  1      DEPTH entries held
//  empty       out  1      zero entries held
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - wr_ptr=0, rd_ptr=0, pkt_cnt=0
//   - data_out=0, empty=1, full=0
//   - memory contents don't-care
//  soft_reset==1 (reset high): same clearing as reset. Has priority over write_enb/read_enb that cycle.
//  Flags, combinational from pointers:
//   - empty = (wr_ptr==rd_ptr)
//   - full  = (wr_ptr[AW]!=rd_ptr[AW]) && (wr_ptr[AW-1:0]==rd_ptr[AW-1:0])
//  Write:
//   - Occurs when write_enb && !full.
//   - mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in}; wr_ptr+1, wraps mod 2*DEPTH.
//   - Write while full: dropped, no pointer change.
//  Read:
//   - Occurs when read_enb && !empty.
//   - data_out <= mem[rd_ptr[AW-1:0]][WIDTH-1:0] on the same edge; rd_ptr+1.
//   - Latency: data valid the cycle after the strobe.
//  Packet counter pkt_cnt (6 bits):
//   - Read word with header flag=1: pkt_cnt <= word[7:2] + 1 (payload length + parity byte).
//   - Read word with header flag=0 and pkt_cnt!=0: pkt_cnt-1.
//  Output gating:
//   - Read with empty=1, or read_enb=0: data_out <= 0 if pkt_cnt==0, else holds.
//   - Last byte of a packet (pkt_cnt 1->0) is presented normally, then data_out returns to 0.
//  Simultaneous read+write:
//   - Both legal: both occur, occupancy unchanged.
//   - When full: only the read occurs (write evaluated against pre-edge full).
//   - When empty: only the write occurs; no bypass, data readable next cycle.
//  Pointers wrap silently; occupancy never exceeds DEPTH nor goes below 0.
//  Reset or soft_reset mid-packet discards remaining bytes; the next header is treated as a fresh packet.
// TESTING
//  1 reset=0 one cycle -> empty=1, full=0, data_out=0.
//  2 Write hdr 8'h0E (lfd=1), 3 payload bytes, parity 8'hA5; then read 5 -> data_out 0E,p0,p1,p2,A5 at 1-cycle latency, then 0.
//  3 Write 16 bytes -> full=1 after 16th; 17th write ignored; 16 reads return original order; empty=1.
//  4 Full FIFO, write_enb=read_enb=1 one cycle -> one read, no write, full=0.
//  5 Fill 10 bytes, pulse soft_reset -> next cycle empty=1, data_out=0; new packet reads correctly.
//  6 Run 40 writes/reads across wrap, occupancy held at 1-3 -> data order intact, no false full/empty.

Source files
------------

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output FIFO of the 1x3 router with packet-length output gating
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [5:0]     pkt_cnt;
    logic           wr_ok;
    logic           rd_ok;
    logic [WIDTH:0] rd_word;
    logic [5:0]     hdr_len;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok   = write_enb && !full;
    assign rd_ok   = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign hdr_len = 6'(rd_word[WIDTH-1:2]);

    always_ff @(posedge clk) begin
        if (reset && !soft_reset && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[WIDTH-1:0];
                // Header carries payload length; +1 accounts for the trailing parity byte
                if (rd_word[WIDTH]) begin
                    pkt_cnt <= hdr_len + 6'd1;
                end else if (pkt_cnt != 6'd0) begin
                    pkt_cnt <= pkt_cnt - 6'd1;
                end
            end else if (pkt_cnt == 6'd0) begin
                data_out <= '0;
            end
        end
    end

endmodule
